// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared single-cycle ALU with SPARC-style icc.
// Accept -> EXEC -> RESP: response valid two cycles after the accept edge; one op in flight.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [5:0]  req0_op,
  input  logic [5:0]  req1_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_res,
  output logic        rsp_err,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  input  logic [31:0] alu_res,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_c,
  output logic [3:0]  icc,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic        prio1_q;
  logic        sel_q;
  logic [5:0]  alu_op_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic        alu_cin_q;
  logic [3:0]  icc_q;
  logic [31:0] rsp_res_q;
  logic        rsp_err_q;

  logic gnt0, gnt1, accept, supported, cc_upd, rsp_hs;

  // prio1_q set means req1 wins the next contention
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (req0_valid && req1_valid) begin
        gnt0 = !prio1_q;
        gnt1 = prio1_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign accept = gnt0 | gnt1;

  always_comb begin
    supported = 1'b0;
    if (!alu_op_q[5])
      supported = (alu_op_q[3:0] <= 4'd8) || (alu_op_q[3:0] == 4'd12);
    else
      supported = (alu_op_q == 6'h25) || (alu_op_q == 6'h26) || (alu_op_q == 6'h27);
  end

  assign cc_upd = supported && (alu_op_q[5:4] == 2'b01);
  assign rsp_hs = (state_q == RESP) && (sel_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    rsp0_valid = (state_q == RESP) && !sel_q;
    rsp1_valid = (state_q == RESP) && sel_q;
    busy       = (state_q != IDLE);
  end

  // ALU drive registers double as the operation latch; icc is stable across EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio1_q   <= 1'b0;
      sel_q     <= 1'b0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cin_q <= 1'b0;
    end else if (accept) begin
      prio1_q   <= gnt0;
      sel_q     <= gnt1;
      alu_op_q  <= gnt1 ? req1_op : req0_op;
      alu_a_q   <= gnt1 ? req1_a  : req0_a;
      alu_b_q   <= gnt1 ? req1_b  : req0_b;
      alu_cin_q <= icc_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icc_q     <= '0;
      rsp_res_q <= '0;
      rsp_err_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_res_q <= supported ? alu_res : 32'd0;
      rsp_err_q <= !supported;
      if (cc_upd) icc_q <= {alu_n, alu_z, alu_v, alu_c};
    end
  end

  assign alu_op  = alu_op_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_cin = alu_cin_q;
  assign icc     = icc_q;
  assign rsp_res = rsp_res_q;
  assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub, round-robin/icc reference model, directed + random ops.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [5:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_res;
  logic        rsp_err;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_cin, alu_n, alu_z, alu_v, alu_c;
  logic [3:0]  icc;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit        pend [2];
  bit [5:0]  pop  [2];
  bit [31:0] pa   [2];
  bit [31:0] pb   [2];
  int        last_g;
  bit [3:0]  icc_m;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .icc(icc), .busy(busy)
  );

  always #5 clk = ~clk;

  // {N,Z,V,C,result}; unsupported encodings return junk so the zeroing is observable
  function automatic logic [35:0] alu_fn(logic [5:0] op, logic [31:0] a, logic [31:0] b, logic cin);
    logic [32:0] s;
    logic        v;
    s = '0;
    v = 1'b0;
    if (op == 6'h25)      s = {1'b0, a << b[4:0]};
    else if (op == 6'h26) s = {1'b0, a >> b[4:0]};
    else if (op == 6'h27) s = {1'b0, 32'($signed(a) >>> b[4:0])};
    else if (op[5])       s = {1'b0, 32'hDEADBEEF};
    else begin
      case (op[3:0])
        4'd0:    s = {1'b0, a} + {1'b0, b};
        4'd8:    s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        4'd4:    s = {1'b0, a} - {1'b0, b};
        4'd12:   s = {1'b0, a} - {1'b0, b} - {32'd0, cin};
        4'd1:    s = {1'b0, a & b};
        4'd2:    s = {1'b0, a | b};
        4'd3:    s = {1'b0, a ^ b};
        4'd5:    s = {1'b0, a & ~b};
        4'd6:    s = {1'b0, a | ~b};
        4'd7:    s = {1'b0, ~(a ^ b)};
        default: s = {1'b0, 32'hDEADBEEF};
      endcase
      if (op[3:0] == 4'd0 || op[3:0] == 4'd8) v = (a[31] == b[31]) && (s[31] != a[31]);
      if (op[3:0] == 4'd4 || op[3:0] == 4'd12) v = (a[31] != b[31]) && (s[31] != a[31]);
    end
    return {s[31], (s[31:0] == 32'd0), v, s[32], s[31:0]};
  endfunction

  function automatic bit ref_sup(bit [5:0] op);
    if (op == 6'h25 || op == 6'h26 || op == 6'h27) return 1'b1;
    if (op >= 6'h20) return 1'b0;
    return (op[3:0] < 4'd9) || (op[3:0] == 4'd12);
  endfunction

  always_comb {alu_n, alu_z, alu_v, alu_c, alu_res} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    req0_valid = pend[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pend[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
  endtask

  task automatic set_req(input int p, input bit [5:0] op, input bit [31:0] a, input bit [31:0] b);
    pend[p] = 1'b1; pop[p] = op; pa[p] = a; pb[p] = b;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_reqs();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    last_g = 1; icc_m = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with pending requests in the model; returns at a negedge in IDLE.
  task automatic serve(input int delay, output bit [31:0] res_o);
    int        g;
    bit [35:0] e;
    bit        sup, cin_m;
    bit [31:0] exp_res;
    res_o = '0;
    drive_reqs();
    #1;
    if (!pend[0] && !pend[1]) return;
    g = (pend[0] && pend[1]) ? ((last_g == 0) ? 1 : 0) : (pend[0] ? 0 : 1);
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    last_g = g;
    cin_m  = icc_m[0];
    sup    = ref_sup(pop[g]);
    e      = alu_fn(pop[g], pa[g], pb[g], cin_m);
    exp_res = sup ? e[31:0] : 32'd0;
    if (sup && pop[g][5:4] == 2'b01) icc_m = e[35:32];
    @(posedge clk); #1;
    pend[g] = 1'b0;
    drive_reqs();
    @(negedge clk);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("exec_alu_op", 32'(alu_op), 32'(pop[g]));
    chk("exec_alu_a", alu_a, pa[g]);
    chk("exec_alu_b", alu_b, pb[g]);
    chk("exec_alu_cin", 32'(alu_cin), 32'(cin_m));
    @(negedge clk);
    chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, (g == 0) ? 32'd1 : 32'd2);
    chk("rsp_res", rsp_res, exp_res);
    chk("rsp_err", 32'(rsp_err), 32'(!sup));
    chk("icc", 32'(icc), 32'(icc_m));
    if (delay > 0) begin
      repeat (delay) @(negedge clk);
      chk("rsp_hold_valid", {30'd0, rsp1_valid, rsp0_valid}, (g == 0) ? 32'd1 : 32'd2);
      chk("rsp_hold_res", rsp_res, exp_res);
    end
    if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    res_o = rsp_res;
  endtask

  bit [5:0] optab [16] = '{6'h00, 6'h01, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18,
                           6'h1C, 6'h12, 6'h25, 6'h26, 6'h27, 6'h09, 6'h20, 6'h3D};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit [31:0] r;
    bit [31:0] edgev [4];
    edgev = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    // reset state, with a live request that must not be acknowledged
    rst_n = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req(0, 6'h10, 32'd1, 32'd2);
    pend[1] = 1'b0;
    drive_reqs();
    #12;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_icc", 32'(icc), 32'd0);
    chk("rst_res", rsp_res, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_cin", 32'(alu_cin), 32'd0);
    apply_reset();

    // ADDcc -> ADDX carry chain, then SUBcc overflow
    set_req(0, 6'h10, 32'hFFFFFFFF, 32'd1);
    serve(0, r);
    chk("addcc_res", r, 32'd0);
    chk("addcc_icc", 32'(icc), 32'b0101);
    set_req(0, 6'h08, 32'd1, 32'd1);
    serve(1, r);
    chk("addx_res", r, 32'd3);
    chk("addx_icc", 32'(icc), 32'b0101);
    set_req(0, 6'h14, 32'h80000000, 32'd1);
    serve(0, r);
    chk("subcc_res", r, 32'h7FFFFFFF);
    chk("subcc_icc", 32'(icc), 32'b0010);

    // contention right after reset, then both held continuously
    apply_reset();
    set_req(0, 6'h00, 32'd1, 32'd2);
    set_req(1, 6'h02, 32'hF0, 32'h0F);
    serve(0, r);
    chk("rr_first_res", r, 32'd3);
    serve(0, r);
    chk("rr_second_res", r, 32'hFF);
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) set_req(p, 6'h03, $urandom, $urandom);
      serve(0, r);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;

    // shift and unsupported opcode on req1
    set_req(0, 6'h10, 32'hFFFFFFFF, 32'd1);
    serve(0, r);
    set_req(1, 6'h25, 32'd1, 32'h23);
    serve(0, r);
    chk("sll_res", r, 32'd8);
    chk("sll_icc", 32'(icc), 32'b0101);
    set_req(1, 6'h09, 32'd5, 32'd6);
    serve(0, r);
    chk("bad_res", r, 32'd0);
    chk("bad_err", 32'(rsp_err), 32'd1);

    // reset in the middle of an ADDcc
    set_req(0, 6'h10, 32'h7FFFFFFF, 32'd1);
    drive_reqs();
    @(posedge clk); #1;
    pend[0] = 1'b0;
    set_req(1, 6'h00, 32'd9, 32'd9);
    drive_reqs();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_icc", 32'(icc), 32'd0);
    chk("mid_rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("mid_rst_ready1", 32'(req1_ready), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    apply_reset();
    set_req(0, 6'h10, 32'd5, 32'd7);
    serve(0, r);
    chk("post_rst_res", r, 32'd12);
    chk("post_rst_icc", 32'(icc), 32'd0);

    // random traffic; a requester left waiting keeps its payload
    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0)
          set_req(p, optab[$urandom_range(0, 15)],
                  ($urandom_range(0, 3) == 0) ? edgev[$urandom_range(0, 3)] : $urandom,
                  ($urandom_range(0, 3) == 0) ? edgev[$urandom_range(0, 3)] : $urandom);
      end
      if (!pend[0] && !pend[1]) set_req(0, optab[$urandom_range(0, 15)], $urandom, $urandom);
      serve($urandom_range(0, 2), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have one clock, clk; reset is rst_n, asynchronous, active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- req0_valid, req1_valid  in  1  requester has an operation.
- req0_ready, req1_ready  out  1  operation accepted this cycle.
- req0_op, req1_op  in  6  ALU opcode.
- req0_a, req0_b, req1_a, req1_b  in  32  operands.
- rsp0_valid, rsp1_valid  out  1  response for that requester.
- rsp0_ready, rsp1_ready  in  1  requester takes the response.
- rsp_res  out  32  registered result.
- rsp_err  out  1  unsupported opcode.
- alu_op  out  6; alu_a, alu_b  out  32; alu_cin  out  1  drive the shared ALU.
- alu_res  in  32; alu_n, alu_z, alu_v, alu_c  in  1  ALU outputs (combinational).
- icc  out  4  integer condition codes {N,Z,V,C}.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-004 In IDLE with at least one reqX_valid, SHALL grant one requester and assert only its reqX_ready combinationally in that cycle; op, a and b latch on that edge; next state is EXEC.
REQ-005 Arbitration SHALL be round-robin: on contention, grant the requester not granted last; last-grant pointer resets to favour req0.
REQ-006 In EXEC, alu_op, alu_a and alu_b SHALL be driven from the latched values, and alu_cin from icc[0] (C).
REQ-007 In EXEC, rsp_res SHALL capture alu_res (or 0 if unsupported) and the FSM SHALL go to RESP.
REQ-008 Outside EXEC, alu_op, alu_a, alu_b and alu_cin SHALL hold their last values.
REQ-009 Supported opcodes SHALL be:
- op[5]=0 with op[3:0] in {0-8, 12};
- 0x25, 0x26, 0x27 (shifts).
Any other opcode SHALL set rsp_err=1, rsp_res=0 and leave icc unchanged.
REQ-010 icc SHALL update from {alu_n, alu_z, alu_v, alu_c} at the end of EXEC only when the op is supported, op[5]=0 and op[4]=1. Shifts and non-cc ops SHALL never change icc.
REQ-011 In RESP, SHALL assert rspX_valid for the granted requester only, holding rsp_res and rsp_err stable until rspX_ready; on that handshake, next state is IDLE.
REQ-012 Latency SHALL be: accept at edge T, rspX_valid high in cycle T+2. Minimum issue interval is 3 cycles; no new grant before returning to IDLE.
REQ-013 A requester SHALL hold reqX_valid and its payload until reqX_ready. The arbiter SHALL NOT grant a requester whose valid is low.
REQ-014 A requester's valid SHALL NOT be lost while the other requester is being serviced; it is granted at the next IDLE.
REQ-015 An icc update SHALL be visible to the very next operation's alu_cin (ADDcc then ADDX chains the carry).

Reset
REQ-016 rst_n low SHALL, at any time including mid-EXEC or mid-RESP, immediately force:
- state IDLE and busy=0;
- icc=0, rsp_res=0, rsp_err=0;
- all ready/valid outputs 0;
- alu_op, alu_a, alu_b, alu_cin = 0;
- last-grant pointer favouring req0.
The in-flight operation is dropped with no response.
REQ-017 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification
REQ-018 req0 op=0x10, a=0xFFFFFFFF, b=1 -> rsp0_valid at T+2, rsp_res=0, icc=0101 (Z,C).
REQ-019 Then req0 op=0x08 (ADDX), a=1, b=1 -> rsp_res=3 (alu_cin=1), icc stays 0101.
REQ-020 req0 op=0x14 (SUBcc), a=0x80000000, b=1 -> rsp_res=0x7FFFFFFF, icc V=1, N=0, Z=0.
REQ-021 After reset, req0 and req1 valid in the same cycle -> req0 granted first, req1 granted at the next IDLE. Repeat with both held -> grants alternate.
REQ-022 req1 op=0x25, a=1, b=0x23 -> rsp_res=8, icc unchanged. req1 op=0x09 -> rsp_err=1, rsp_res=0.
REQ-023 Drop rst_n during EXEC of an ADDcc -> no rsp valid, icc=0, busy=0. A new request after release completes normally with rsp_res checked against its expected result.
